// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage_if
// Purpose  : Upstream instruction and downstream result handshake bundle
//            for alu_issue_stage.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            in_opcode;
    logic [2:0]            in_funct3;
    logic                  in_funct7b5;
    logic [REG_ADDR_W-1:0] in_rs1;
    logic [REG_ADDR_W-1:0] in_rs2;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [XLEN-1:0]       in_rs1_data;
    logic [XLEN-1:0]       in_rs2_data;
    logic [XLEN-1:0]       in_imm;
    logic [XLEN-1:0]       in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_result;
    logic                  out_zero;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_illegal;

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_rd,
               in_rs1_data, in_rs2_data, in_imm, in_pc, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_rd, out_illegal
    );

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_rd,
               in_rs1_data, in_rs2_data, in_imm, in_pc, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_rd, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Two-stage RV32I ALU issue: decode/operand register, then ALU
//            result register, valid/ready on both sides.
//            Optional operand bypass: define ALU_ISSUE_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         flush,
    alu_issue_stage_if.slave  bus
);
    localparam logic [6:0] c_OPC_R     = 7'b0110011;
    localparam logic [6:0] c_OPC_I     = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;

    localparam logic [3:0] c_ADD  = 4'b0000;
    localparam logic [3:0] c_SUB  = 4'b0001;
    localparam logic [3:0] c_AND  = 4'b0010;
    localparam logic [3:0] c_OR   = 4'b0011;
    localparam logic [3:0] c_XOR  = 4'b0100;
    localparam logic [3:0] c_SLTU = 4'b0101;
    localparam logic [3:0] c_SLT  = 4'b0110;
    localparam logic [3:0] c_SLL  = 4'b0111;
    localparam logic [3:0] c_SRL  = 4'b1000;
    localparam logic [3:0] c_SRA  = 4'b1001;

    logic                  r_s1_valid, r_s1_illegal;
    logic [XLEN-1:0]       r_s1_in0, r_s1_in1;
    logic [3:0]            r_s1_op;
    logic [REG_ADDR_W-1:0] r_s1_rd;
    logic                  r_s2_valid, r_s2_zero, r_s2_illegal;
    logic [XLEN-1:0]       r_s2_result;
    logic [REG_ADDR_W-1:0] r_s2_rd;

    logic                  w_s2_ready, w_in_ready, w_in_fire;
    logic [XLEN-1:0]       w_rs1_val, w_rs2_val;
    logic [XLEN-1:0]       w_dec_in0, w_dec_in1;
    logic [3:0]            w_dec_op, w_f3_op;
    logic                  w_dec_illegal;
    logic [XLEN-1:0]       w_alu_result;
    logic                  w_alu_zero;

    // in_ready depends only on registered state and out_ready
    assign w_s2_ready = !r_s2_valid | bus.out_ready;
    assign w_in_ready = !r_s1_valid | w_s2_ready;
    assign w_in_fire  = bus.in_valid & w_in_ready;

`ifdef ALU_ISSUE_FWD_EN
    logic w_s1_hit1, w_s1_hit2, w_s2_hit1, w_s2_hit2;
    assign w_s1_hit1 = r_s1_valid & !r_s1_illegal & (bus.in_rs1 != '0) & (bus.in_rs1 == r_s1_rd);
    assign w_s1_hit2 = r_s1_valid & !r_s1_illegal & (bus.in_rs2 != '0) & (bus.in_rs2 == r_s1_rd);
    assign w_s2_hit1 = r_s2_valid & !r_s2_illegal & (bus.in_rs1 != '0) & (bus.in_rs1 == r_s2_rd);
    assign w_s2_hit2 = r_s2_valid & !r_s2_illegal & (bus.in_rs2 != '0) & (bus.in_rs2 == r_s2_rd);
    assign w_rs1_val = w_s1_hit1 ? w_alu_result : (w_s2_hit1 ? r_s2_result : bus.in_rs1_data);
    assign w_rs2_val = w_s1_hit2 ? w_alu_result : (w_s2_hit2 ? r_s2_result : bus.in_rs2_data);
`else
    logic w_unused;
    assign w_unused  = ^{bus.in_rs1, bus.in_rs2};
    assign w_rs1_val = bus.in_rs1_data;
    assign w_rs2_val = bus.in_rs2_data;
`endif

    always_comb begin
        w_f3_op = c_ADD;
        case (bus.in_funct3)
            3'b000:  w_f3_op = ((bus.in_opcode == c_OPC_R) && bus.in_funct7b5) ? c_SUB : c_ADD;
            3'b001:  w_f3_op = c_SLL;
            3'b010:  w_f3_op = c_SLT;
            3'b011:  w_f3_op = c_SLTU;
            3'b100:  w_f3_op = c_XOR;
            3'b101:  w_f3_op = bus.in_funct7b5 ? c_SRA : c_SRL;
            3'b110:  w_f3_op = c_OR;
            default: w_f3_op = c_AND;
        endcase
    end

    always_comb begin
        w_dec_illegal = 1'b0;
        w_dec_op      = c_ADD;
        w_dec_in0     = '0;
        w_dec_in1     = '0;
        case (bus.in_opcode)
            c_OPC_R: begin
                w_dec_in0 = w_rs1_val;
                w_dec_in1 = w_rs2_val;
                w_dec_op  = w_f3_op;
            end
            c_OPC_I: begin
                w_dec_in0 = w_rs1_val;
                w_dec_in1 = bus.in_imm;
                w_dec_op  = w_f3_op;
            end
            c_OPC_LUI: begin
                w_dec_in1 = bus.in_imm;
            end
            c_OPC_AUIPC: begin
                w_dec_in0 = bus.in_pc;
                w_dec_in1 = bus.in_imm;
            end
            default: w_dec_illegal = 1'b1;
        endcase
        if (w_dec_op == c_SLL || w_dec_op == c_SRL || w_dec_op == c_SRA) begin
            w_dec_in1 = {{(XLEN-5){1'b0}}, w_dec_in1[4:0]};
        end
    end

    always_comb begin
        w_alu_result = r_s1_in0 + r_s1_in1;
        case (r_s1_op)
            c_SUB:   w_alu_result = r_s1_in0 - r_s1_in1;
            c_AND:   w_alu_result = r_s1_in0 & r_s1_in1;
            c_OR:    w_alu_result = r_s1_in0 | r_s1_in1;
            c_XOR:   w_alu_result = r_s1_in0 ^ r_s1_in1;
            c_SLTU:  w_alu_result = {{(XLEN-1){1'b0}}, (r_s1_in0 < r_s1_in1)};
            c_SLT:   w_alu_result = {{(XLEN-1){1'b0}}, ($signed(r_s1_in0) < $signed(r_s1_in1))};
            c_SLL:   w_alu_result = r_s1_in0 << r_s1_in1[4:0];
            c_SRL:   w_alu_result = r_s1_in0 >> r_s1_in1[4:0];
            c_SRA:   w_alu_result = $unsigned($signed(r_s1_in0) >>> r_s1_in1[4:0]);
            default: w_alu_result = r_s1_in0 + r_s1_in1;
        endcase
    end
    assign w_alu_zero = (w_alu_result == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_illegal <= 1'b0;
            r_s1_in0     <= '0;
            r_s1_in1     <= '0;
            r_s1_op      <= c_ADD;
            r_s1_rd      <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_result  <= '0;
            r_s2_zero    <= 1'b0;
            r_s2_rd      <= '0;
            r_s2_illegal <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_in_fire) begin
                r_s1_in0     <= w_dec_in0;
                r_s1_in1     <= w_dec_in1;
                r_s1_op      <= w_dec_op;
                r_s1_rd      <= bus.in_rd;
                r_s1_illegal <= w_dec_illegal;
            end
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
            end
            if (r_s1_valid && w_s2_ready) begin
                r_s2_result  <= w_alu_result;
                r_s2_zero    <= w_alu_zero;
                r_s2_rd      <= r_s1_rd;
                r_s2_illegal <= r_s1_illegal;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_s2_valid;
    assign bus.out_result  = r_s2_result;
    assign bus.out_zero    = r_s2_zero;
    assign bus.out_rd      = r_s2_rd;
    assign bus.out_illegal = r_s2_illegal;
endmodule
`default_nettype wire
